// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage. Owns the fetch PC, issues one word fetch at a time
//   to instruction memory over a req/ready + rvalid handshake, buffers the
//   returned words in a small prefetch FIFO and presents the head entry as
//   {instruction, PC, PC+4} to the IF/ID register. A redirect flushes the
//   FIFO and restarts fetching at the branch target; a response that was
//   already in flight when the redirect arrived is dropped.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   redirect, target_addr      taken branch and its target
//   id_ld                      IF/ID consumes the head entry this cycle
//   imem_req/addr/ready        fetch request channel
//   imem_rvalid/rdata          fetch response channel
//   if_valid/instr/pc/pc4      head entry (NOP_WORD / 0 / 0 when empty)
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_WORD = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] target_addr,
    input  logic        id_ld,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    localparam int             PW       = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0]     DEPTH_C  = 3'(DEPTH);
    localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             fetch_pc_q, fetch_pc_d;
    logic [31:0]             req_pc_q, req_pc_d;
    logic [DEPTH-1:0][31:0]  instr_q, instr_d;
    logic [DEPTH-1:0][31:0]  pc_q, pc_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [2:0]              count_q, count_d;

    logic [2:0]              space;
    logic                    accept;
    logic                    push;
    logic                    pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Head entry straight from the FIFO storage flops.
    assign if_valid = (count_q != 3'd0);
    assign if_instr = if_valid ? instr_q[rd_ptr_q] : NOP_WORD;
    assign if_pc    = if_valid ? pc_q[rd_ptr_q] : 32'h0;
    assign if_pc4   = if_valid ? pc_q[rd_ptr_q] + 32'd4 : 32'h0;

    always_comb begin
        // An outstanding request reserves a slot so its push can never overflow.
        space     = DEPTH_C - count_q - {2'b00, (state_q == ST_WAIT)};
        // rst_n gate keeps the request low while reset is held.
        imem_req  = rst_n && (state_q == ST_REQ) && (space != 3'd0) && !redirect;
        imem_addr = fetch_pc_q;
        accept    = imem_req && imem_ready;
        push      = (state_q == ST_WAIT) && imem_rvalid && !redirect;
        pop       = if_valid && id_ld && !redirect;

        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect)
            fetch_pc_d = target_addr & 32'hFFFF_FFFC;
        else if (accept)
            fetch_pc_d = fetch_pc_q + 32'd4;
        if (accept)
            req_pc_d = fetch_pc_q;

        // Redirect never coincides with an accept (request is masked), so a
        // redirect in REQ simply stays in REQ. A response landing together
        // with a redirect is consumed here (push is suppressed above).
        state_d = state_q;
        case (state_q)
            ST_REQ:  if (accept) state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem_rvalid)   state_d = ST_REQ;
                else if (redirect) state_d = ST_DROP;
            end
            ST_DROP: if (imem_rvalid) state_d = ST_REQ;
            default: state_d = ST_REQ;
        endcase

        instr_d  = instr_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = 3'd0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = imem_rdata;
                pc_d[wr_ptr_q]    = req_pc_q;
                wr_ptr_d          = ptr_inc(wr_ptr_q);
            end
            if (pop)
                rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0;
            instr_q    <= '0;
            pc_q       <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined ARM-subset core.
- Owns the PC and issues word fetches to instruction memory over a request/response handshake.
- Buffers fetched words in a small prefetch FIFO and presents {instruction, PC, PC+4} to the IF/ID pipeline register.
- Honours the hazard-unit load enable and the branch redirect from the condition handler.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch FIFO entries; legal values 2..4.
- NOP_WORD, 32'hE1A0_0000, instruction driven when no valid entry is presented (MOV r0,r0).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect  in  1  taken branch (choose_ta_r_nop); flush and refetch.
- target_addr  in  32  branch target address.
- id_ld  in  1  hazard unit load enable; 1 means IF/ID consumes the head entry this cycle.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  head entry valid.
- if_instr  out  32  head instruction, or NOP_WORD when empty.
- if_pc  out  32  address of head instruction, 0 when empty.
- if_pc4  out  32  if_pc+4 (Next_PC), 0 when empty.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - fetch_pc=RESET_PC, FIFO empty, state=REQ, discard flag cleared.
  - imem_req=0, if_valid=0, if_instr=NOP_WORD, if_pc=0, if_pc4=0.
  - Takes effect immediately, including mid-WAIT. A response arriving after reset is ignored.
- Slot accounting:
  - space = DEPTH - count - (state==WAIT ? 1 : 0).
  - A request may only issue when space > 0, so a push never overflows.
- State machine:
  - REQ: imem_req = (space>0) && !redirect; imem_addr=fetch_pc. On imem_req && imem_ready: fetch_pc += 4 (modulo 2^32, wraps to 0), go to WAIT. While imem_ready=0, imem_req and imem_addr hold stable.
  - WAIT: imem_req=0, one request outstanding. On imem_rvalid: push {imem_rdata, pc_of_request}, go to REQ.
  - DROP: imem_req=0, outstanding response is stale. On imem_rvalid: discard it, no push, go to REQ.
  - imem_rvalid in REQ is ignored.
- Latency and throughput:
  - Accept in cycle N, rvalid no earlier than N+1.
  - if_valid rises the cycle after the push.
  - Peak rate is one instruction per 2 cycles, because only one request is outstanding at a time.
- Output and pop:
  - Outputs are driven from the registered FIFO head.
  - Pop occurs when if_valid && id_ld.
  - Push and pop in the same cycle: count is unchanged and order is preserved.
  - id_ld=0: head is held, the FIFO fills to DEPTH, then requests stop.
- Redirect (highest priority, sampled at the clock edge):
  - fetch_pc = {target_addr[31:2], 2'b00}; misaligned low bits are cleared.
  - FIFO is flushed; a pop or push in the same cycle is cancelled.
  - If state is WAIT, or a request is accepted in the same cycle, next state is DROP.
  - If an outstanding response has imem_rvalid in the same cycle as redirect, that response is discarded and next state is REQ.
  - Otherwise next state is REQ.
  - if_valid is 0 in the cycle after a redirect.
  - imem_req is forced 0 while redirect=1.
- Redirect while in DROP: fetch_pc is updated, state stays DROP.

Test Plan:
- Reset, RESET_PC=0, imem_ready=1, rvalid one cycle after accept, id_ld=1 -> imem_addr 0x0,0x4,0x8; if_pc follows in order; if_pc4=if_pc+4; no gaps beyond the 1-per-2 rate.
- id_ld=0 for 10 cycles -> FIFO holds 2 entries (pc 0x0,0x4), imem_req=0, if_pc stays 0x0; then id_ld=1 -> 0x0,0x4,0x8 presented with no loss or duplication.
- Redirect to 0x40 while WAIT on 0x8 -> response for 0x8 dropped, next imem_addr=0x40, first valid if_pc=0x40, if_instr=NOP_WORD in between.
- Redirect target 0x0000_0043 -> imem_addr=0x40.
- rst_n low while WAIT, then rvalid pulses with rst_n high -> pulse ignored; first request is RESET_PC; if_valid=0 until that request returns.
- imem_ready=0 for 3 cycles with fetch_pc=0xFFFF_FFFC -> imem_req=1 and imem_addr=0xFFFF_FFFC stable; after accept, next address is 0x0 (wrap).
